// File: rtl/inner_rr_arbiter.sv
// Round-robin arbiter that shares one valid/rdata/ready resource port among NUM_REQ requesters.
// Each transaction runs grant -> issue -> capture -> respond, and a timeout bounds the issue phase.
module inner_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_grant,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               res_valid,
    input  logic [DATA_W-1:0]  res_rdata,
    input  logic               res_ready
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_MAX = (TIMEOUT > 0) ? TW'(TIMEOUT) : {TW{1'b1}};
    localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [PW-1:0]       ptr_reg;
    logic [PW-1:0]       idx_reg;
    logic [TW-1:0]       timer_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic                rsp_err_reg;

    logic                pick_found;
    logic [PW-1:0]       pick_idx;
    logic [PW:0]         cand;
    logic                timeout_hit;

    // Scan ptr, ptr+1, ... modulo NUM_REQ; the extra bit avoids overflow before the wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_reg} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (!pick_found && req_valid[cand[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (timer_reg == TIMER_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (pick_found) state_next = S_ISSUE;
            S_ISSUE: if (res_ready || timeout_hit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Ready has priority over the timeout, so a response on the last allowed cycle is kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg      <= '0;
            idx_reg      <= '0;
            timer_reg    <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pick_found) begin
                        idx_reg   <= pick_idx;
                        timer_reg <= '0;
                    end
                end
                S_ISSUE: begin
                    if (res_ready) begin
                        rsp_data_reg <= res_rdata;
                        rsp_err_reg  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_data_reg <= '0;
                        rsp_err_reg  <= 1'b1;
                    end else if (timer_reg != TIMER_MAX) begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    ptr_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
                end
                default: begin
                    ptr_reg <= ptr_reg;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign req_grant[gi] = (state_reg == S_ISSUE || state_reg == S_DONE)
                                   && (idx_reg == PW'(gi));
            assign rsp_valid[gi] = (state_reg == S_DONE) && (idx_reg == PW'(gi));
        end
    endgenerate

    always_comb begin
        busy      = (state_reg == S_ISSUE) || (state_reg == S_DONE);
        res_valid = (state_reg == S_ISSUE);
    end

    assign rsp_data = rsp_data_reg;
    assign rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_inner_rr_arbiter.sv
// Randomized bench for inner_rr_arbiter: the driver predicts each transaction from the arbitration
// rules, records a per-cycle output timeline plus a response queue, and monitors check both.
module tb_inner_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_grant;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic          res_valid;
    logic [DW-1:0] res_rdata;
    logic          res_ready;

    inner_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_grant (req_grant),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .res_valid (res_valid),
        .res_rdata (res_rdata),
        .res_ready (res_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
        logic          err;
        int            at;
    } rsp_t;

    rsp_t           rsp_q[$];
    rsp_t           mon_e;
    logic [2*N+1:0] exp_tl [int];
    int             cyc   = 0;
    int             n_cmp = 0;
    int             n_bad = 0;
    int             mptr  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [N-1:0] onehot(int w);
        return N'(1) << w;
    endfunction

    // Reference arbitration: first requester at or after the rotating pointer.
    function automatic int pick(logic [N-1:0] p);
        int j;
        for (int off = 0; off < N; off++) begin
            j = (mptr + off) % N;
            if (((p >> j) & N'(1)) != '0) return j;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            exp_tl[cyc] = '0;
            req_valid   = '0;
            res_ready   = 1'($urandom);
            res_rdata   = DW'($urandom);
            step();
        end
    endtask

    // Called in a cycle where the arbiter is idle. d = ISSUE cycle index carrying ready
    // (beyond TO means it never comes); abort >= 0 pulses reset in that ISSUE cycle.
    task automatic txn(logic [N-1:0] pattern, int d, bit drop, int abort, logic [DW-1:0] data);
        int            w;
        int            k_eff;
        int            last;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        w     = pick(pattern);
        k_eff = (d <= TO) ? d : TO;
        last  = (abort >= 0) ? abort : k_eff;
        exp_tl[cyc] = '0;
        req_valid   = pattern;
        res_ready   = 1'($urandom);
        res_rdata   = DW'($urandom);
        for (int i = 0; i <= last; i++) begin
            step();
            exp_tl[cyc] = {onehot(w), N'(0), 1'b1, 1'b1};
            if (drop) req_valid = '0;
            if (abort >= 0 && i == abort) begin
                reset     = 1'b1;
                res_ready = 1'b0;
            end else if (i == d) begin
                res_ready = 1'b1;
                res_rdata = data;
            end else begin
                res_ready = 1'b0;
                res_rdata = DW'($urandom);
            end
        end
        step();
        if (abort >= 0) begin
            reset     = 1'b0;
            req_valid = '0;
            mptr      = 0;
            $display("txn aborted by reset: req=%b winner=%0d cyc=%0d", pattern, w, cyc);
        end else begin
            exp_err  = (d > TO);
            exp_data = exp_err ? '0 : data;
            exp_tl[cyc] = {onehot(w), onehot(w), 1'b1, 1'b0};
            rsp_q.push_back('{w, exp_data, exp_err, cyc});
            mptr      = (w + 1) % N;
            req_valid = N'($urandom);
            res_ready = 1'($urandom);
            res_rdata = DW'($urandom);
            step();
        end
    endtask

    always @(negedge clock) begin
        if (exp_tl.exists(cyc)) begin
            n_cmp++;
            if ({req_grant, rsp_valid, busy, res_valid} !== exp_tl[cyc]) begin
                n_bad++;
                $display("FAIL timeline cyc=%0d got grant=%b rsp=%b busy=%b res_valid=%b, want {grant,rsp,busy,res_valid}=%b",
                         cyc, req_grant, rsp_valid, busy, res_valid, exp_tl[cyc]);
            end
        end
        if (rsp_valid != '0) begin
            n_cmp++;
            if (rsp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_rsp cyc=%0d got rsp_valid=%b, want no response", cyc, rsp_valid);
            end else begin
                mon_e = rsp_q.pop_front();
                if (rsp_valid !== onehot(mon_e.who) || rsp_data !== mon_e.data ||
                    rsp_err !== mon_e.err || cyc != mon_e.at) begin
                    n_bad++;
                    $display("FAIL rsp cyc=%0d got rsp_valid=%b data=%h err=%b, want rsp_valid=%b data=%h err=%b at cyc=%0d",
                             cyc, rsp_valid, rsp_data, rsp_err, onehot(mon_e.who), mon_e.data, mon_e.err, mon_e.at);
                end else begin
                    $display("rsp requester=%0d data=%h err=%b cyc=%0d", mon_e.who, rsp_data, rsp_err, cyc);
                end
            end
        end
    end

    initial begin
        int            d;
        int            k_eff;
        int            abort;
        int            r;
        logic [N-1:0]  pat;
        reset     = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        res_rdata = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        idle(10);
        txn(4'b0010, 0, 1'b0, -1, 4'h5);
        for (int i = 0; i < 8; i++) txn(4'b1111, 0, 1'b0, -1, DW'($urandom));
        txn(4'b0001, TO + 5, 1'b0, -1, DW'($urandom));
        txn(4'b0100, TO, 1'b0, -1, 4'hA);
        txn(4'b1100, 10, 1'b0, 2, DW'($urandom));
        txn(4'b1010, 1, 1'b0, -1, DW'($urandom));
        txn(4'b0110, 3, 1'b1, -1, DW'($urandom));
        idle(2);

        for (int t = 0; t < 60; t++) begin
            pat = N'($urandom_range(1, (1 << N) - 1));
            r   = $urandom_range(0, 9);
            if (r < 5)      d = $urandom_range(0, 3);
            else if (r < 7) d = TO;
            else if (r < 8) d = TO + 1 + $urandom_range(0, 2);
            else            d = $urandom_range(0, TO);
            k_eff = (d <= TO) ? d : TO;
            abort = ($urandom_range(0, 14) == 0) ? $urandom_range(0, k_eff) : -1;
            txn(pat, d, ($urandom_range(0, 4) == 0), abort, DW'($urandom));
            idle($urandom_range(0, 2));
        end

        idle(4);
        n_cmp++;
        if (rsp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_rsp got %0d responses outstanding, want 0", rsp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
